// File: rtl/bist_controller.sv
// bist_controller: sequences scan_en for an LFSR-fed scan chain BIST.
// A run is one load shift followed by NUM_PATTERNS capture/unload pairs.
// During each unload shift the serial scan_out stream is folded into a
// MISR. At the end of the run the signature is compared with GOLDEN_SIG.
module bist_controller #(
    parameter int                   CHAIN_LEN    = 8,
    parameter int                   NUM_PATTERNS = 8,
    parameter int                   SIG_WIDTH    = 8,
    parameter logic [SIG_WIDTH-1:0] MISR_POLY    = 8'h1D,
    parameter logic [SIG_WIDTH-1:0] MISR_SEED    = 8'h00,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature
);

    localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PAT_W = $clog2(NUM_PATTERNS + 1);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [PAT_W-1:0]     pat_cnt;
    logic [SIG_WIDTH-1:0] misr;
    logic [SIG_WIDTH-1:0] misr_nxt;

    // One MISR step: shift left, fold in the polynomial when the MSB falls
    // out, then inject the new serial bit at the LSB.
    function automatic logic [SIG_WIDTH-1:0] misr_step(
        input logic [SIG_WIDTH-1:0] cur,
        input logic                 din
    );
        logic [SIG_WIDTH-1:0] nxt;
        nxt = {cur[SIG_WIDTH-2:0], 1'b0};
        if (cur[SIG_WIDTH-1]) begin
            nxt = nxt ^ MISR_POLY;
        end
        nxt[0] = nxt[0] ^ din;
        return nxt;
    endfunction

    // Next MISR value if the current cycle is an unload shift.
    always_comb begin
        misr_nxt = misr_step(misr, scan_out);
    end

    assign signature = misr;

    // Sequencer: state, counters, MISR and registered outputs together so
    // outputs change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            pat_cnt <= '0;
            misr    <= MISR_SEED;
            scan_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        bit_cnt <= '0;
                        pat_cnt <= '0;
                        misr    <= MISR_SEED;
                        scan_en <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bit_cnt == LAST_BIT) begin
                        state   <= CAPTURE;
                        bit_cnt <= '0;
                        scan_en <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + PAT_W'(1);
                    state   <= UNLOAD;
                    scan_en <= 1'b1;
                end
                UNLOAD: begin
                    misr <= misr_nxt;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        scan_en <= 1'b0;
                        if (pat_cnt == LAST_PAT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (misr_nxt == GOLDEN_SIG);
                        end else begin
                            state <= CAPTURE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    scan_en <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: randomized and directed bench for bist_controller
// with a run-index based reference model.
module tb_bist_controller;

    localparam int         CL      = 8;
    localparam int         NP      = 8;
    localparam int         RUN_LEN = CL + NP * (1 + CL);
    localparam logic [7:0] POLY    = 8'h1D;
    localparam logic [7:0] SEED    = 8'h00;
    localparam logic [7:0] GOLD    = 8'h00;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       scan_out = 1'b0;
    logic       scan_en;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;

    bist_controller #(
        .CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SIG_WIDTH(8),
        .MISR_POLY(POLY), .MISR_SEED(SEED), .GOLDEN_SIG(GOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(scan_en), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a run is indexed 0..RUN_LEN-1 by cycle. Index < CL is
    // the load shift; afterwards every (CL+1)-cycle group starts with one
    // capture cycle followed by CL unload shifts.
    bit         m_run  = 1'b0;
    bit         m_done = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_sig  = SEED;

    function automatic bit is_shift(input int t);
        if (t < CL) return 1'b1;
        return ((t - CL) % (CL + 1)) != 0;
    endfunction

    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic d);
        int v;
        v = int'(s) * 2;
        if (v >= 256) v = (v - 256) ^ int'(POLY);
        return 8'(v) ^ {7'b0, d};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_done = 1'b0; m_t = 0; m_sig = SEED;
        end else if (m_run) begin
            if (m_t >= CL && is_shift(m_t)) m_sig = misr_ref(m_sig, scan_out);
            m_t++;
            if (m_t == RUN_LEN) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            m_run = 1'b1; m_t = 0; m_done = 1'b0; m_sig = SEED;
        end
    end

    // Per-cycle comparison of every output against the model.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("scan_en", 32'(scan_en), 32'(m_run && is_shift(m_t)));
            check("busy", 32'(busy), 32'(m_run));
            check("done", 32'(done), 32'(m_done));
            check("pass", 32'(pass), 32'(m_done && (m_sig == GOLD)));
            check("signature", 32'(signature), 32'(m_sig));
        end
    end

    // scan_out stimulus: 0 tied low, 1 tied high, 2 random,
    // 3 single pulse on unload cycle RUN_LEN-1-so_off.
    int so_mode = 0;
    int so_off  = 0;

    task automatic drive_scan();
        case (so_mode)
            0: scan_out = 1'b0;
            1: scan_out = 1'b1;
            2: scan_out = 1'($urandom);
            default: scan_out = m_run && (m_t == RUN_LEN - 1 - so_off);
        endcase
    endtask

    // Starts one run from a negedge and returns at the negedge where done
    // is seen (or after a bounded wait).
    task automatic run_one(input int mode, input int off, input int mid_start_at,
                           output int busy_cnt, output int done_at, output int low_cnt);
        so_mode = mode;
        so_off  = off;
        start   = 1'b1;
        drive_scan();
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        low_cnt  = 0;
        done_at  = -1;
        for (int n = 1; n <= RUN_LEN + 20; n++) begin
            if (n == 1) begin
                check("done_clear", 32'(done), 32'(0));
                check("pass_clear", 32'(pass), 32'(0));
                check("sig_reseed", 32'(signature), 32'(SEED));
            end
            if (busy) busy_cnt++;
            if (busy && !scan_en) low_cnt++;
            if (done) begin
                done_at = n;
                break;
            end
            start = (n == mid_start_at);
            drive_scan();
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int bc, da, lc;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scan_en", 32'(scan_en), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_pass", 32'(pass), 32'(0));
        check("rst_sig", 32'(signature), 32'(8'h00));
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // scan_out tied low: signature stays at seed, pass.
        run_one(0, 0, 0, bc, da, lc);
        check("zero_done_at", 32'(da), 32'(RUN_LEN + 1));
        check("zero_busy_cycles", 32'(bc), 32'(80));
        check("zero_low_pulses", 32'(lc), 32'(8));
        check("zero_sig", 32'(signature), 32'(8'h00));
        check("zero_pass", 32'(pass), 32'(1));

        // scan_out tied high, started from DONE: fails, still on time.
        run_one(1, 0, 0, bc, da, lc);
        check("ones_done_at", 32'(da), 32'(81));
        check("ones_sig_nonzero", 32'(signature != 8'h00), 32'(1));
        check("ones_pass", 32'(pass), 32'(0));

        // Single pulses near the end of the last unload, one with a
        // start pulse 30 cycles into the run that must be ignored.
        run_one(3, 0, 30, bc, da, lc);
        check("pulse_last_sig", 32'(signature), 32'(8'h01));
        check("pulse_last_pass", 32'(pass), 32'(0));
        check("mid_start_done_at", 32'(da), 32'(81));
        run_one(3, 1, 0, bc, da, lc);
        check("pulse_m1_sig", 32'(signature), 32'(8'h02));
        run_one(3, 2, 0, bc, da, lc);
        check("pulse_m2_sig", 32'(signature), 32'(8'h04));

        // Asynchronous reset in the middle of the first unload.
        so_mode = 2;
        start   = 1'b1;
        drive_scan();
        @(negedge clk);
        start = 1'b0;
        repeat (11) begin
            drive_scan();
            @(negedge clk);
        end
        check("pre_rst_busy", 32'(busy), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_scan_en", 32'(scan_en), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        check("async_done", 32'(done), 32'(0));
        check("async_pass", 32'(pass), 32'(0));
        check("async_sig", 32'(signature), 32'(8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'(0));

        // start held high: back-to-back runs through one DONE cycle.
        start = 1'b1;
        repeat (3 * (RUN_LEN + 1) + 5) begin
            drive_scan();
            @(negedge clk);
        end
        start = 1'b0;

        // Random start requests and scan data, with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 29) == 0);
            drive_scan();
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
